// File: rtl/axismcast_pkg.sv
// Shared types for the AXI-Stream multicast block.
// port_state_t is the per-port packet tracker, visible on dbg_state.
package axismcast_pkg;

  typedef enum logic [1:0] {
    PS_IDLE   = 2'd0,
    PS_ACTIVE = 2'd1,
    PS_SKIP   = 2'd2,
    PS_DROP   = 2'd3
  } port_state_t;

endpackage

// File: rtl/axismcast_port.sv
// One multicast output port: packet FIFO with speculative/committed write pointers,
// first-word fall-through read side and a packet state tracker.
module axismcast_port
  import axismcast_pkg::*;
#(
  parameter int DW       = 16,
  parameter int LGFIFO   = 4,
  parameter bit OPT_DROP = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_fire,
  input  logic          wr_sel,
  input  logic          wr_last,
  input  logic [DW-1:0] wr_data,
  output logic          space,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          o_drop,
  output logic [1:0]    state_dbg
);

  localparam int FW    = LGFIFO + 1;
  localparam int DEPTH = 1 << LGFIFO;

  logic [DW:0]   mem [DEPTH];
  logic [FW-1:0] wr_ptr, cmt_ptr, rd_ptr, vis_ptr;
  port_state_t   state;
  logic          full, wr_try, wr_en, overflow, rd_fire;

  // Full counts uncommitted beats too, so an oversize packet always overflows
  assign full     = (wr_ptr - rd_ptr) == FW'(DEPTH);
  assign space    = !full;
  assign vis_ptr  = OPT_DROP ? cmt_ptr : wr_ptr;
  assign m_valid  = rd_ptr != vis_ptr;
  assign {m_last, m_data} = mem[rd_ptr[LGFIFO-1:0]];
  assign rd_fire  = m_valid && m_ready;

  assign wr_try   = wr_fire && wr_sel && (state != PS_DROP);
  assign overflow = wr_try && full && OPT_DROP;
  assign wr_en    = wr_try && !full;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      rd_ptr  <= '0;
      o_drop  <= 1'b0;
      state   <= PS_IDLE;
    end else begin
      o_drop <= overflow;
      if (rd_fire)
        rd_ptr <= rd_ptr + FW'(1);
      if (overflow) begin
        wr_ptr <= cmt_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + FW'(1);
        if (wr_last)
          cmt_ptr <= wr_ptr + FW'(1);
      end
      if (wr_fire) begin
        if (wr_last)
          state <= PS_IDLE;
        else if (overflow)
          state <= PS_DROP;
        else if (state == PS_IDLE)
          state <= wr_sel ? PS_ACTIVE : PS_SKIP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[LGFIFO-1:0]] <= {wr_last, wr_data};
  end

endmodule

// File: rtl/axismcast_skid.sv
// Input skid buffer.
// Beats pass through combinationally while empty; one beat is held when downstream stalls.
module axismcast_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic         full;
  logic [W-1:0] skid_data;

  assign m_valid = full || (s_valid && s_ready);
  assign m_data  = full ? skid_data : s_data;

  // s_ready is held low through reset and rises on the first clock after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 1'b0;
      s_ready <= 1'b0;
    end else if (full) begin
      if (m_ready) begin
        full    <= 1'b0;
        s_ready <= 1'b1;
      end
    end else if (s_valid && s_ready && !m_ready) begin
      full    <= 1'b1;
      s_ready <= 1'b0;
    end else begin
      s_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!full && s_valid && s_ready && !m_ready)
      skid_data <= s_data;
  end

endmodule

// File: rtl/axismcast.sv
// AXI-Stream multicast: one slave stream replicated to NM masters with a per-packet
// destination mask taken from the first beat. OPT_DROP picks stall vs per-port drop.
module axismcast
  import axismcast_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH = 16,
  parameter int NM                = 4,
  parameter int LGFIFO            = 4,
  parameter bit OPT_DROP          = 1'b0
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  input  logic                           S_AXIS_TVALID,
  output logic                           S_AXIS_TREADY,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic                           S_AXIS_TLAST,
  input  logic [NM-1:0]                  S_AXIS_TDEST,
  output logic [NM-1:0]                  M_AXIS_TVALID,
  input  logic [NM-1:0]                  M_AXIS_TREADY,
  output logic [NM*C_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic [NM-1:0]                  M_AXIS_TLAST,
  output logic [NM-1:0]                  o_drop,
  output logic [2*NM-1:0]                dbg_state
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = NM + 1 + DW;

  // Every stream here transfers a beat exactly on a clock edge where valid && ready;
  // valid never waits on ready, and once raised data stays stable until the transfer.
  logic          beat_valid, beat_ready, beat_fire, beat_last;
  logic [DW-1:0] beat_data;
  logic [NM-1:0] beat_dest, eff_mask, cur_mask, port_space;
  logic          pkt_start;

  axismcast_skid #(.W(SW)) u_skid (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .s_valid (S_AXIS_TVALID),
    .s_ready (S_AXIS_TREADY),
    .s_data  ({S_AXIS_TDEST, S_AXIS_TLAST, S_AXIS_TDATA}),
    .m_valid (beat_valid),
    .m_ready (beat_ready),
    .m_data  ({beat_dest, beat_last, beat_data})
  );

  // Mid-packet TDEST is ignored: only the first beat's mask is used
  assign eff_mask   = pkt_start ? beat_dest : cur_mask;
  assign beat_ready = OPT_DROP ? 1'b1 : &(~eff_mask | port_space);
  assign beat_fire  = beat_valid && beat_ready;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      pkt_start <= 1'b1;
      cur_mask  <= '0;
    end else if (beat_fire) begin
      pkt_start <= beat_last;
      if (pkt_start)
        cur_mask <= beat_dest;
    end
  end

  for (genvar k = 0; k < NM; k++) begin : g_port
    axismcast_port #(
      .DW       (DW),
      .LGFIFO   (LGFIFO),
      .OPT_DROP (OPT_DROP)
    ) u_port (
      .clk       (S_AXI_ACLK),
      .rst_n     (S_AXI_ARESETN),
      .wr_fire   (beat_fire),
      .wr_sel    (eff_mask[k]),
      .wr_last   (beat_last),
      .wr_data   (beat_data),
      .space     (port_space[k]),
      .m_valid   (M_AXIS_TVALID[k]),
      .m_ready   (M_AXIS_TREADY[k]),
      .m_data    (M_AXIS_TDATA[k*DW +: DW]),
      .m_last    (M_AXIS_TLAST[k]),
      .o_drop    (o_drop[k]),
      .state_dbg (dbg_state[2*k +: 2])
    );
  end

endmodule

// File: tb/tb_axismcast.sv
// Bench for axismcast: a cut-through instance and a drop-mode instance side by side,
// random packets checked by a packet-level reference model and an output scoreboard.
module tb_axismcast;

  localparam int DW    = 16;
  localparam int NM    = 4;
  localparam int LG    = 4;
  localparam int DEPTH = 16;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_valid [2] = '{1'b0, 1'b0};
  logic          s_ready [2];
  logic [DW-1:0] s_data  [2] = '{'0, '0};
  logic          s_last  [2] = '{1'b0, 1'b0};
  logic [NM-1:0] s_dest  [2] = '{'0, '0};
  logic [NM-1:0] m_valid [2];
  logic [NM-1:0] m_ready [2] = '{'0, '0};
  logic [NM*DW-1:0] m_data [2];
  logic [NM-1:0] m_last  [2];
  logic [NM-1:0] o_drop  [2];
  logic [2*NM-1:0] dbg   [2];

  axismcast #(.C_AXIS_DATA_WIDTH(DW), .NM(NM), .LGFIFO(LG), .OPT_DROP(1'b0)) u_cut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXIS_TVALID(s_valid[0]), .S_AXIS_TREADY(s_ready[0]), .S_AXIS_TDATA(s_data[0]),
    .S_AXIS_TLAST(s_last[0]), .S_AXIS_TDEST(s_dest[0]),
    .M_AXIS_TVALID(m_valid[0]), .M_AXIS_TREADY(m_ready[0]), .M_AXIS_TDATA(m_data[0]),
    .M_AXIS_TLAST(m_last[0]), .o_drop(o_drop[0]), .dbg_state(dbg[0]));

  axismcast #(.C_AXIS_DATA_WIDTH(DW), .NM(NM), .LGFIFO(LG), .OPT_DROP(1'b1)) u_drop (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXIS_TVALID(s_valid[1]), .S_AXIS_TREADY(s_ready[1]), .S_AXIS_TDATA(s_data[1]),
    .S_AXIS_TLAST(s_last[1]), .S_AXIS_TDEST(s_dest[1]),
    .M_AXIS_TVALID(m_valid[1]), .M_AXIS_TREADY(m_ready[1]), .M_AXIS_TDATA(m_data[1]),
    .M_AXIS_TLAST(m_last[1]), .o_drop(o_drop[1]), .dbg_state(dbg[1]));

  // scoreboard and model state
  logic [DW:0] exp_q [2][NM][$];
  int n_vec = 0;
  int n_err = 0;
  int rdy_mode [2][NM];       // 0: hold low, 1: hold high, 2: random
  int occ       [NM];         // drop instance: beats parked in a never-ready port
  int drop_exp  [NM];
  int drop_seen [NM];
  int drop0_seen = 0;

  initial begin
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < NM; p++) rdy_mode[i][p] = 1;
    for (int p = 0; p < NM; p++) begin
      occ[p] = 0; drop_exp[p] = 0; drop_seen[p] = 0;
    end
  end

  // consumer ready, changed just after the active edge
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < NM; p++)
        m_ready[i][p] = (rdy_mode[i][p] == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode[i][p] == 1);
  end

  // monitor: pops the expected queue on every output transfer
  always @(negedge clk) begin
    logic [DW:0] got, want;
    if (rst_n) begin
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < NM; p++)
          if (m_valid[i][p] && m_ready[i][p]) begin
            got = {m_last[i][p], m_data[i][p*DW +: DW]};
            n_vec++;
            if (exp_q[i][p].size() == 0) begin
              n_err++;
              $display("FAIL out_i%0d_p%0d: got beat %h, required no beat", i, p, got);
            end else begin
              want = exp_q[i][p].pop_front();
              if (got !== want) begin
                n_err++;
                $display("FAIL out_i%0d_p%0d: got %h, required %h", i, p, got, want);
              end
            end
          end
      for (int p = 0; p < NM; p++)
        if (o_drop[1][p]) drop_seen[p]++;
      if (o_drop[0] != '0) drop0_seen++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // driver tasks
  task automatic drive_beat(input int i, input logic [DW-1:0] d, input logic last,
                            input logic [NM-1:0] dest, input int budget, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    s_valid[i] = 1'b1; s_data[i] = d; s_last[i] = last; s_dest[i] = dest;
    for (int t = 0; t < budget; t++) begin
      if (s_ready[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int i, input int n);
    @(negedge clk);
    s_valid[i] = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // Sends one packet; later beats carry random TDEST that must be ignored.
  // Drop instance model: a port keeps a packet only if it fits next to what is parked.
  task automatic send_pkt(input int i, input logic [NM-1:0] mask, input int len, input int gap_max);
    logic [DW:0]   beats[$];
    logic [DW-1:0] d;
    logic [NM-1:0] dest;
    logic          last;
    bit            ok;
    int            base;
    for (int b = 0; b < len; b++) begin
      d    = DW'($urandom);
      dest = (b == 0) ? mask : NM'($urandom);
      last = (b == len - 1);
      drive_beat(i, d, last, dest, 300, ok);
      if (!ok) begin
        n_vec++; n_err++;
        $display("FAIL accept_i%0d: beat %0d not accepted, required within 300 cycles", i, b);
        s_valid[i] = 1'b0;
        return;
      end
      beats.push_back({last, d});
      if (i == 0)
        for (int p = 0; p < NM; p++)
          if (mask[p]) exp_q[0][p].push_back({last, d});
      if (gap_max > 0 && $urandom_range(0, 3) == 0) idle(i, $urandom_range(1, gap_max));
    end
    idle(i, 1);
    if (i == 1)
      for (int p = 0; p < NM; p++)
        if (mask[p]) begin
          base = (rdy_mode[1][p] == 0) ? occ[p] : 0;
          if (base + len > DEPTH) drop_exp[p]++;
          else begin
            foreach (beats[b]) exp_q[1][p].push_back(beats[b]);
            if (rdy_mode[1][p] == 0) occ[p] += len;
          end
        end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < NM; p++)
        if (exp_q[i][p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input int budget);
    int t = 0;
    while (t < budget && !all_empty()) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < NM; p++)
        check($sformatf("drain_i%0d_p%0d", i, p), exp_q[i][p].size(), 0);
  endtask

  task automatic set_modes(input int i, input int m0, input int m1, input int m2, input int m3);
    rdy_mode[i][0] = m0; rdy_mode[i][1] = m1; rdy_mode[i][2] = m2; rdy_mode[i][3] = m3;
  endtask

  task automatic check_drops();
    repeat (3) @(negedge clk);
    for (int p = 0; p < NM; p++)
      check($sformatf("drop_count_p%0d", p), drop_seen[p], drop_exp[p]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            ok, stalled;
    logic [DW-1:0] d;
    logic [NM-1:0] dest;
    logic          last;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_tready_i%0d", i), s_ready[i], 0);
      check($sformatf("reset_tvalid_i%0d", i), m_valid[i], 0);
      check($sformatf("reset_drop_i%0d", i), o_drop[i], 0);
      check($sformatf("reset_state_i%0d", i), dbg[i], 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 3-beat packet to ports 0 and 2
    send_pkt(0, 4'b0101, 3, 0);
    wait_drain(100);

    // empty mask packet vanishes; next packet routes by first beat only
    send_pkt(0, 4'b0000, 4, 0);
    send_pkt(0, 4'b0010, 5, 0);
    wait_drain(100);

    // backpressure: port1 never ready, 20-beat packet to ports 0,1
    set_modes(0, 1, 0, 1, 1);
    stalled = 1'b0;
    for (int b = 0; b < 20; b++) begin
      d = DW'($urandom);
      dest = (b == 0) ? 4'b0011 : NM'($urandom);
      last = (b == 19);
      drive_beat(0, d, last, dest, 40, ok);
      if (!ok && !stalled) begin
        stalled = 1'b1;
        n_vec++;
        if (b < 16 || b > 17) begin
          n_err++;
          $display("FAIL stall_depth: source stalled after %0d beats, required 16 or 17", b);
        end
        check("stall_tready", s_ready[0], 0);
        rdy_mode[0][1] = 1;
        drive_beat(0, d, last, dest, 300, ok);
      end
      if (!ok) begin
        n_vec++; n_err++;
        $display("FAIL stall_resume: beat %0d not accepted, required acceptance", b);
        break;
      end
      exp_q[0][0].push_back({last, d});
      exp_q[0][1].push_back({last, d});
    end
    idle(0, 1);
    check("stall_seen", stalled, 1);
    wait_drain(200);

    // random cut-through traffic
    set_modes(0, 2, 2, 2, 2);
    for (int n = 0; n < 40; n++)
      send_pkt(0, NM'($urandom), $urandom_range(1, 24), 3);
    wait_drain(3000);

    // drop mode: port1 never ready, 6-beat packets to ports 0,1
    set_modes(1, 1, 0, 1, 1);
    for (int n = 0; n < 3; n++) begin
      send_pkt(1, 4'b0011, 6, 0);
      idle(1, 30);
    end
    check_drops();
    check("drop_p1_pulses", drop_seen[1], 1);
    set_modes(1, 1, 1, 1, 1);
    wait_drain(200);
    for (int p = 0; p < NM; p++) occ[p] = 0;

    // oversize packet to port2 is always dropped
    send_pkt(1, 4'b0100, 20, 0);
    idle(1, 30);
    check_drops();
    wait_drain(100);

    // random drop-mode rounds with fixed ready patterns
    for (int r = 0; r < 2; r++) begin
      if (r == 0) set_modes(1, 1, 0, 1, 0);
      else        set_modes(1, 0, 1, 0, 1);
      for (int n = 0; n < 15; n++) begin
        send_pkt(1, NM'($urandom), $urandom_range(1, 20), 0);
        idle(1, 30);
      end
      check_drops();
      set_modes(1, 1, 1, 1, 1);
      wait_drain(400);
      for (int p = 0; p < NM; p++) occ[p] = 0;
    end

    // reset in the middle of a packet, during the clock-low phase
    set_modes(0, 0, 0, 0, 0);
    for (int b = 0; b < 2; b++) begin
      drive_beat(0, DW'($urandom), 1'b0, 4'b1111, 50, ok);
      check($sformatf("partial_accept_%0d", b), ok, 1);
    end
    idle(0, 3);
    check("partial_visible", m_valid[0], 4'hf);
    #2 rst_n = 1'b0;
    #1;
    check("async_tvalid", m_valid[0], 0);
    check("async_tready", s_ready[0], 0);
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < NM; p++) exp_q[i][p].delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    set_modes(0, 1, 1, 1, 1);
    send_pkt(0, 4'b0101, 4, 0);
    wait_drain(100);

    check("cut_no_drop", drop0_seen, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
